// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Purpose
//   Fractional baud-rate generator for a UART. A cycle counter produces a
//   one-cycle os_tick at the end of every oversample interval. A phase counter
//   (os_count) groups OVERSAMPLE os_ticks into one bit period. It flags the
//   bit centre (mid_tick) and the bit end (baud_tick).
//
//   The divisors are held in shadow registers. They are captured on load, on
//   the rising edge of en, and on every baud_tick. A divisor change in the
//   middle of a bit therefore never distorts that bit.
//
//   The effective integer divisor is max(baud_div_int, 1). With divisor 1,
//   os_tick stays high on every enabled cycle.
//
// Configuration
//   UART_BAUD_FRAC_EN  defined   : a FRAC_WIDTH-bit accumulator adds
//                                  baud_div_frac at every os_tick. Its
//                                  carry-out stretches the next interval by
//                                  one cycle.
//   UART_BAUD_FRAC_EN  undefined : no accumulator and baud_div_frac is
//                                  ignored. Every interval is exactly the
//                                  effective integer divisor.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   en             in   generator enable; low holds everything at zero
//   load           in   synchronous restart; also captures new divisors
//   baud_div_int   in   [DIV_WIDTH]  integer clock cycles per os_tick
//   baud_div_frac  in   [FRAC_WIDTH] fractional cycles per os_tick (1/2^FRAC_WIDTH)
//   os_tick        out  one-cycle oversample pulse
//   mid_tick       out  one-cycle bit-centre pulse (os_count == OVERSAMPLE/2-1)
//   baud_tick      out  one-cycle bit-end pulse    (os_count == OVERSAMPLE-1)
//   os_count       out  [$clog2(OVERSAMPLE)] oversample phase of the current tick
//
// Parameters
//   DIV_WIDTH   integer divisor width
//   FRAC_WIDTH  fractional divisor width
//   OVERSAMPLE  os_ticks per baud_tick; even, 4..64
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV_WIDTH  = 32,
  parameter int FRAC_WIDTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [DIV_WIDTH-1:0]          baud_div_int,
  input  logic [FRAC_WIDTH-1:0]         baud_div_frac,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_count
);

  localparam int               OSC_W   = $clog2(OVERSAMPLE);
  localparam logic [OSC_W-1:0] OS_LAST = OSC_W'(OVERSAMPLE - 1);
  localparam logic [OSC_W-1:0] OS_MID  = OSC_W'(OVERSAMPLE / 2 - 1);

  // ---------------------------------------------------------------------------
  // Control FSM
  //   ST_IDLE : disabled, or never started since reset. The first cycle with
  //             en high is treated as an en rising edge. This also covers en
  //             already being high when rst_n releases.
  //   ST_RUN  : counting.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   restart;  // clear datapath and capture divisors at this edge
  logic   run;      // datapath advances at this edge

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    restart = 1'b0;
    run     = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (load || (state_q == ST_IDLE)) begin
      // Load wins over any tick that would have fired at this edge.
      state_d = ST_RUN;
      restart = 1'b1;
    end else begin
      run = 1'b1;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=). Every flop then
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interval counter and tick generation
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] shadow_int_q, shadow_int_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] eff_div;
  logic [DIV_WIDTH:0]   last_idx;    // L-1; one extra bit because L may reach 2^DIV_WIDTH
  logic                 last_cycle;
  logic                 frac_carry;  // stretches the current interval by one cycle
  logic                 capture;
  logic [OSC_W-1:0]     os_count_q, os_count_d;
  logic                 os_tick_q, os_tick_d;
  logic                 mid_tick_q, mid_tick_d;
  logic                 baud_tick_q, baud_tick_d;

  // A divisor of 0 behaves as 1.
  assign eff_div = (shadow_int_q == '0) ? DIV_WIDTH'(1) : shadow_int_q;

  assign last_idx = {1'b0, eff_div} + (DIV_WIDTH + 1)'(frac_carry)
                    - (DIV_WIDTH + 1)'(1);

  assign last_cycle = (last_idx == {1'b0, cnt_q});

  always_comb begin
    cnt_d       = '0;
    os_count_d  = '0;
    os_tick_d   = 1'b0;
    mid_tick_d  = 1'b0;
    baud_tick_d = 1'b0;
    if (run) begin
      cnt_d = last_cycle ? '0 : cnt_q + DIV_WIDTH'(1);

      // os_count shows the phase of the tick that is (or was last) on the
      // output. It advances on the edge that ends an os_tick cycle, so
      // back-to-back ticks with divisor 1 still step it once per tick.
      os_count_d = os_count_q;
      if (os_tick_q) begin
        os_count_d = (os_count_q == OS_LAST) ? '0 : os_count_q + OSC_W'(1);
      end

      os_tick_d   = last_cycle;
      mid_tick_d  = last_cycle && (os_count_d == OS_MID);
      baud_tick_d = last_cycle && (os_count_d == OS_LAST);
    end
  end

  // The bit boundary (baud_tick) is the only in-flight capture point. The
  // interval that starts at that edge already uses the new divisor.
  assign capture      = load | restart | baud_tick_d;
  assign shadow_int_d = capture ? baud_div_int : shadow_int_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_int_q <= '0;
      cnt_q        <= '0;
      os_count_q   <= '0;
      os_tick_q    <= 1'b0;
      mid_tick_q   <= 1'b0;
      baud_tick_q  <= 1'b0;
    end else begin
      shadow_int_q <= shadow_int_d;
      cnt_q        <= cnt_d;
      os_count_q   <= os_count_d;
      os_tick_q    <= os_tick_d;
      mid_tick_q   <= mid_tick_d;
      baud_tick_q  <= baud_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fractional accumulator
  // ---------------------------------------------------------------------------
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] shadow_frac_q, shadow_frac_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  carry_q, carry_d;

  // At each os_tick the old fraction is added. Its carry-out lengthens the
  // interval that starts at that same edge. The accumulator restarts from
  // zero whenever the generator restarts or is disabled.
  always_comb begin
    acc_d   = '0;
    carry_d = 1'b0;
    if (run) begin
      if (last_cycle) begin
        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, shadow_frac_q};
      end else begin
        acc_d   = acc_q;
        carry_d = carry_q;
      end
    end
  end

  assign shadow_frac_d = capture ? baud_div_frac : shadow_frac_q;
  assign frac_carry    = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_frac_q <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
    end else begin
      shadow_frac_q <= shadow_frac_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
    end
  end
`else
  // Integer-only build: every interval is exactly the effective divisor.
  logic unused_frac;
  assign unused_frac = ^baud_div_frac;
  assign frac_carry  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs are driven straight from flops: no combinational input-to-output
  // path.
  // ---------------------------------------------------------------------------
  assign os_tick   = os_tick_q;
  assign mid_tick  = mid_tick_q;
  assign baud_tick = baud_tick_q;
  assign os_count  = os_count_q;

  // Structural relationships between the tick outputs.
  a_baud_on_os: assert property (@(posedge clk) disable iff (!rst_n)
                                 baud_tick |-> os_tick);
  a_mid_on_os:  assert property (@(posedge clk) disable iff (!rst_n)
                                 mid_tick |-> os_tick);
  a_mid_baud:   assert property (@(posedge clk) disable iff (!rst_n)
                                 !(mid_tick && baud_tick));

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Self-checking bench for uart_baud_gen (default parameters).
//
// A behavioural model tracks:
//   - the cycles remaining until the next os_tick,
//   - the number of ticks since the last restart,
//   - the fractional accumulator.
// It predicts every output on every cycle. Directed sequences then measure
// tick spacing against fixed expected periods, and a randomized phase
// exercises en, load, divisor changes and reset.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int DW  = 32;
  localparam int FW  = 4;
  localparam int OS  = 16;
  localparam int OCW = $clog2(OS);

`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           en       = 1'b0;
  logic           load     = 1'b0;
  logic [DW-1:0]  div_int  = '0;
  logic [FW-1:0]  div_frac = '0;
  logic           os_tick;
  logic           mid_tick;
  logic           baud_tick;
  logic [OCW-1:0] os_count;

  uart_baud_gen #(
    .DIV_WIDTH (DW),
    .FRAC_WIDTH(FW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .load         (load),
    .baud_div_int (div_int),
    .baud_div_frac(div_frac),
    .os_tick      (os_tick),
    .mid_tick     (mid_tick),
    .baud_tick    (baud_tick),
    .os_count     (os_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit     m_en_prev = 1'b0;
  longint m_sh_int  = 0;
  longint m_sh_frac = 0;
  longint m_rem     = 0;  // cycles left until the next os_tick
  longint m_ticks   = 0;  // os_ticks since the last restart
  longint m_acc     = 0;
  bit     e_os      = 1'b0;
  bit     e_mid     = 1'b0;
  bit     e_baud    = 1'b0;
  int     e_cnt     = 0;
  bit     m_rise;
  longint m_phase;
  longint m_sum;
  longint m_carry;

  function automatic longint eff(input longint d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en_prev = 1'b0;
      m_sh_int  = 0;
      m_sh_frac = 0;
      m_rem     = 0;
      m_ticks   = 0;
      m_acc     = 0;
      e_os      = 1'b0;
      e_mid     = 1'b0;
      e_baud    = 1'b0;
      e_cnt     = 0;
    end else begin
      m_rise    = en && !m_en_prev;
      m_en_prev = en;
      e_os      = 1'b0;
      e_mid     = 1'b0;
      e_baud    = 1'b0;
      if (load || !en || m_rise) begin
        m_ticks = 0;
        m_acc   = 0;
        if (load || m_rise) begin
          m_sh_int  = div_int;
          m_sh_frac = div_frac;
        end
        m_rem = eff(m_sh_int);
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          e_os    = 1'b1;
          m_phase = m_ticks % OS;
          e_mid   = (m_phase == OS / 2 - 1);
          e_baud  = (m_phase == OS - 1);
          m_ticks++;
          m_sum   = m_acc + (FRAC_ON ? m_sh_frac : 0);
          m_carry = m_sum / (1 << FW);
          m_acc   = m_sum % (1 << FW);
          if (e_baud) begin
            m_sh_int  = div_int;
            m_sh_frac = div_frac;
          end
          m_rem = eff(m_sh_int) + m_carry;
        end
      end
      e_cnt = e_os ? int'((m_ticks - 1) % OS) : int'(m_ticks % OS);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cycle", {os_tick, mid_tick, baud_tick, os_count},
          {e_os, e_mid, e_baud, OCW'(e_cnt)});
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Counts negedges until the selected output is seen high (0=os, 1=mid,
  // 2=baud). Bounded; on expiry the count is left at the bound.
  task automatic wait_sig(input int which, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = (which == 0) ? os_tick : (which == 1) ? mid_tick : baud_tick;
    end while (!s && n < 10000);
  endtask

  // Loads new divisors; returns on the negedge right after the capture edge.
  task automatic do_load(input logic [DW-1:0] d, input logic [FW-1:0] f);
    @(negedge clk);
    div_int  = d;
    div_frac = f;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int cnt;
    int exp_frac[5];

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outputs", {os_tick, mid_tick, baud_tick, os_count}, '0);
    #2 rst_n = 1'b1;

    // Divisor 130, started by an en rising edge.
    @(negedge clk);
    div_int  = 130;
    div_frac = 0;
    en       = 1'b1;
    @(negedge clk);
    wait_sig(0, n); check("t1_first_os", n, 130);
    wait_sig(0, n); check("t1_os_gap", n, 130);
    wait_sig(2, n); check("t1_first_baud", n, 14 * 130);
    wait_sig(2, n); check("t1_baud_gap", n, 2080);

    // Fractional divisor 10 + 8/16.
    if (FRAC_ON) exp_frac = '{10, 10, 11, 10, 11};
    else         exp_frac = '{10, 10, 10, 10, 10};
    do_load(10, 8);
    for (int i = 0; i < 5; i++) begin
      wait_sig(0, n);
      check($sformatf("t2_frac_gap%0d", i), n, exp_frac[i]);
    end

    // Divisor 0 and 1: os_tick continuously high, baud_tick every 16 cycles.
    do_load(0, 0);
    wait_sig(0, n); check("t3_div0_first", n, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("t3_div0_os_high", os_tick, 1'b1);
    end
    wait_sig(2, n);
    wait_sig(2, n); check("t3_div0_baud_gap", n, 16);
    do_load(1, 0);
    check("t3_load_quiet", {os_tick, mid_tick, baud_tick, os_count}, '0);
    wait_sig(0, n); check("t3_div1_first", n, 1);
    wait_sig(2, n);
    wait_sig(2, n); check("t3_div1_baud_gap", n, 16);

    // 130 -> 65 mid-bit without load: old period holds until the bit ends.
    do_load(130, 0);
    wait_sig(0, n); check("t5_first", n, 130);
    wait_sig(0, n);
    wait_sig(0, n);
    div_int = 65;
    for (int i = 0; i < 13; i++) begin
      wait_sig(0, n);
      check("t5_old_period", n, 130);
    end
    check("t5_baud_at_old", baud_tick, 1'b1);
    wait_sig(0, n); check("t5_new_period", n, 65);

    // 130 -> 65 with load landing on the edge of a due os_tick.
    do_load(130, 0);
    wait_sig(0, n);
    div_int = 65;
    repeat (129) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("t5_load_quiet", {os_tick, mid_tick, baud_tick, os_count}, '0);
    wait_sig(0, n); check("t5_load_restart", n, 65);

    // Asynchronous reset mid-interval with en held high.
    repeat (20) @(negedge clk);
    check("t6_pre_rst_count", (os_count != 0), 1'b1);
    #2 rst_n = 1'b0;
    #1 check("t6_rst_async", {os_tick, mid_tick, baud_tick, os_count}, '0);
    repeat (3) @(negedge clk);
    check("t6_rst_held", {os_tick, mid_tick, baud_tick, os_count}, '0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wait_sig(0, n); check("t6_first_after_rst", n, 65);

    // mid_tick on phase 7, eight os_ticks before baud_tick.
    do_load(3, 0);
    wait_sig(1, n);
    check("t7_mid_phase", os_count, 7);
    cnt = 0;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
      if (os_tick) cnt++;
    end while (!baud_tick && n < 1000);
    check("t7_mid_to_baud", cnt, 8);

    // Disable: everything held at zero.
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("t8_disabled", {os_tick, mid_tick, baud_tick, os_count}, '0);

    // Randomized phase, checked cycle by cycle against the model.
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) div_int = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) div_frac = FW'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 20000000 expected");
    $fatal(1, "watchdog expired");
  end

endmodule
